// File: rtl/segasys1_sndcmd_rx.sv
// Sound command receiver for the Sega System 1 sound CPU.
// Captures command bytes from the main CPU into a 2-deep queue, raises an NMI
// while a command is pending, and generates the periodic 4 ms sound IRQ.
//
// IRQ FSM
//   state      | meaning
//   IRQ_IDLE   | SNDIRQ low, waiting for the free counter to wrap
//   IRQ_ACTIVE | SNDIRQ high, length counter running down
module segasys1_sndcmd_rx #(
    parameter int unsigned IRQ_DIV = 160000,
    parameter int unsigned IRQ_LEN = 2048,
    parameter int unsigned NMI_GAP = 16
) (
    input  logic        CLK40M,
    input  logic        RESET,
    input  logic        SNDRQ,
    input  logic [7:0]  SNDNO,
    input  logic [15:0] SCPU_AD,
    input  logic        SCPU_MREQ,
    input  logic        SCPU_RD,
    input  logic        SCPU_IACK,
    input  logic        PAUSE_N,
    output logic        CMD_CS,
    output logic [7:0]  CMD_DO,
    output logic        SNDNMI,
    output logic        SNDIRQ,
    output logic        OVERRUN
);

    localparam int DW = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;
    localparam int LW = $clog2(IRQ_LEN + 1);
    localparam int GW = $clog2(NMI_GAP + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(IRQ_DIV - 1);
    localparam logic [LW-1:0] LEN_LAST = LW'(IRQ_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(NMI_GAP);

    typedef enum logic {
        IRQ_IDLE   = 1'b0,
        IRQ_ACTIVE = 1'b1
    } irq_state_t;

    logic          sndrq_q;
    logic          armed_q;
    logic          cs_q;
    logic [1:0]    cnt_q,  cnt_d;
    logic [7:0]    head_q, head_d;
    logic [7:0]    tail_q, tail_d;
    logic          ovr_q,  ovr_d;
    logic [GW-1:0] gap_q,  gap_d;
    logic [DW-1:0] div_q,  div_d;
    logic [LW-1:0] len_q,  len_d;
    irq_state_t    irq_q,  irq_d;

    logic push;
    logic pop;
    logic wrap;

    // Read decode and the edge/strobe conditions that drive the queue.
    // armed_q blocks a push from a strobe already high when reset releases.
    always_comb begin
        CMD_CS = (SCPU_AD[15:12] == 4'hE) && SCPU_MREQ && SCPU_RD;
        push   = SNDRQ && !sndrq_q && armed_q;
        pop    = cs_q && !CMD_CS && (cnt_q != 2'd0);
        wrap   = PAUSE_N && (div_q == DIV_LAST);
    end

    // Queue next state: a pop shifts the tail forward before any push lands.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        ovr_d  = ovr_q;
        if (pop && push) begin
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
                tail_d = SNDNO;
            end else begin
                head_d = SNDNO;
            end
        end else if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push) begin
            case (cnt_q)
                2'd0: begin
                    head_d = SNDNO;
                    cnt_d  = 2'd1;
                end
                2'd1: begin
                    tail_d = SNDNO;
                    cnt_d  = 2'd2;
                end
                default: ovr_d = 1'b1;
            endcase
        end
    end

    // NMI gap reload on pop so a second queued command gives a new NMI edge.
    always_comb begin
        gap_d = gap_q;
        if (pop) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // Free-running IRQ period counter, frozen while paused.
    always_comb begin
        div_d = div_q;
        if (PAUSE_N) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
    end

    // IRQ FSM next state; a wrap seen while active is ignored.
    always_comb begin
        irq_d = irq_q;
        len_d = len_q;
        case (irq_q)
            IRQ_IDLE: begin
                if (wrap) begin
                    irq_d = IRQ_ACTIVE;
                    len_d = LEN_LAST;
                end
            end
            IRQ_ACTIVE: begin
                if (PAUSE_N) begin
                    if (SCPU_IACK || (len_q == '0)) begin
                        irq_d = IRQ_IDLE;
                    end else begin
                        len_d = len_q - LW'(1);
                    end
                end
            end
            default: irq_d = IRQ_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge CLK40M or posedge RESET) begin
        if (RESET) begin
            sndrq_q <= 1'b0;
            armed_q <= 1'b0;
            cs_q    <= 1'b0;
            cnt_q   <= 2'd0;
            head_q  <= 8'h00;
            tail_q  <= 8'h00;
            ovr_q   <= 1'b0;
            gap_q   <= '0;
            div_q   <= '0;
            len_q   <= '0;
            irq_q   <= IRQ_IDLE;
        end else begin
            sndrq_q <= SNDRQ;
            armed_q <= 1'b1;
            cs_q    <= CMD_CS;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovr_q   <= ovr_d;
            gap_q   <= gap_d;
            div_q   <= div_d;
            len_q   <= len_d;
            irq_q   <= irq_d;
        end
    end

    // Outputs.
    always_comb begin
        CMD_DO  = (cnt_q != 2'd0) ? head_q : 8'h00;
        SNDNMI  = (cnt_q != 2'd0) && (gap_q == '0);
        SNDIRQ  = (irq_q == IRQ_ACTIVE);
        OVERRUN = ovr_q;
    end

endmodule

// File: tb/tb_segasys1_sndcmd_rx.sv
// Bench for segasys1_sndcmd_rx: directed scenarios followed by random traffic,
// all compared every cycle against a queue/integer reference model.
module tb_segasys1_sndcmd_rx;

    localparam int DIV = 100;
    localparam int LEN = 10;
    localparam int GAP = 16;

    logic        CLK40M    = 1'b0;
    logic        RESET     = 1'b1;
    logic        SNDRQ     = 1'b0;
    logic [7:0]  SNDNO     = 8'h00;
    logic [15:0] SCPU_AD   = 16'h0000;
    logic        SCPU_MREQ = 1'b0;
    logic        SCPU_RD   = 1'b0;
    logic        SCPU_IACK = 1'b0;
    logic        PAUSE_N   = 1'b1;
    logic        CMD_CS;
    logic [7:0]  CMD_DO;
    logic        SNDNMI;
    logic        SNDIRQ;
    logic        OVERRUN;

    segasys1_sndcmd_rx #(
        .IRQ_DIV(DIV),
        .IRQ_LEN(LEN),
        .NMI_GAP(GAP)
    ) dut (
        .CLK40M   (CLK40M),
        .RESET    (RESET),
        .SNDRQ    (SNDRQ),
        .SNDNO    (SNDNO),
        .SCPU_AD  (SCPU_AD),
        .SCPU_MREQ(SCPU_MREQ),
        .SCPU_RD  (SCPU_RD),
        .SCPU_IACK(SCPU_IACK),
        .PAUSE_N  (PAUSE_N),
        .CMD_CS   (CMD_CS),
        .CMD_DO   (CMD_DO),
        .SNDNMI   (SNDNMI),
        .SNDIRQ   (SNDIRQ),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK40M = ~CLK40M;

    // Reference model state.
    logic [7:0] mq[$];
    bit         m_ovr;
    int         m_gap;
    bit         m_prq;
    bit         m_pcs;
    bit         m_arm;
    int         m_t;
    bit         m_irq;
    int         m_age;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dec_cs();
        return (SCPU_AD[15:12] == 4'hE) && SCPU_MREQ && SCPU_RD;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr = 0; m_gap = 0; m_prq = 0; m_pcs = 0; m_arm = 0;
        m_t = 0; m_irq = 0; m_age = 0;
    endtask

    task automatic model_edge();
        bit cs, push, pop, wrap;
        cs   = dec_cs();
        push = m_arm && SNDRQ && !m_prq;
        pop  = m_pcs && !cs && (mq.size() > 0);
        if (pop) begin
            void'(mq.pop_front());
            m_gap = GAP;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        if (push) begin
            if (mq.size() < 2) mq.push_back(SNDNO);
            else m_ovr = 1;
        end
        m_prq = SNDRQ;
        m_pcs = cs;
        m_arm = 1;
        if (PAUSE_N) begin
            wrap = (m_t == DIV - 1);
            m_t  = wrap ? 0 : m_t + 1;
            if (m_irq) begin
                m_age++;
                if (SCPU_IACK || m_age == LEN) m_irq = 0;
            end else if (wrap) begin
                m_irq = 1;
                m_age = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("cmd_cs", {15'd0, CMD_CS}, {15'd0, dec_cs()});
        check("cmd_do", {8'd0, CMD_DO}, {8'd0, (mq.size() > 0) ? mq[0] : 8'h00});
        check("sndnmi", {15'd0, SNDNMI}, {15'd0, (mq.size() > 0) && (m_gap == 0)});
        check("sndirq", {15'd0, SNDIRQ}, {15'd0, m_irq});
        check("overrun", {15'd0, OVERRUN}, {15'd0, m_ovr});
    endtask

    task automatic step();
        @(posedge CLK40M);
        model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic push_cmd(input logic [7:0] b, input int len);
        SNDRQ = 1'b1;
        SNDNO = b;
        repeat (len) step();
        SNDRQ = 1'b0;
        step();
    endtask

    task automatic rd_cmd(input logic [7:0] exp, input string tag);
        SCPU_AD   = 16'hE000;
        SCPU_MREQ = 1'b1;
        SCPU_RD   = 1'b1;
        check(tag, {8'd0, CMD_DO}, {8'd0, exp});
        step();
        SCPU_MREQ = 1'b0;
        SCPU_RD   = 1'b0;
        step();
    endtask

    task automatic wait_rise(output int c);
        int  b;
        bit  was;
        b   = 0;
        was = SNDIRQ;
        c   = -1;
        while (b < 300 && c < 0) begin
            step();
            b++;
            if (!was && SNDIRQ) c = cyc;
            was = SNDIRQ;
        end
        if (c < 0) begin
            check("irq_timeout", 16'd1, 16'd0);
            c = cyc;
        end
    endtask

    initial begin
        int r1, r2, r3, r4, cnt;

        model_reset();
        repeat (3) @(posedge CLK40M);
        #1;
        compare_all();
        check("rst_do", {8'd0, CMD_DO}, 16'h0000);
        check("rst_irq", {15'd0, SNDIRQ}, 16'h0000);
        @(negedge CLK40M);
        RESET = 1'b0;
        step();

        // Single command, three-cycle strobe.
        SNDRQ = 1'b1;
        SNDNO = 8'h5A;
        step();
        check("single_nmi", {15'd0, SNDNMI}, 16'd1);
        check("single_do", {8'd0, CMD_DO}, 16'h005A);
        step();
        step();
        SNDRQ = 1'b0;
        step();
        rd_cmd(8'h5A, "single_rd");
        check("single_nmi_off", {15'd0, SNDNMI}, 16'd0);
        check("single_empty", {8'd0, CMD_DO}, 16'h0000);

        // Back-to-back commands with NMI gap.
        push_cmd(8'h11, 1);
        push_cmd(8'h22, 2);
        rd_cmd(8'h11, "b2b_rd1");
        cnt = SNDNMI ? 0 : 1;
        for (int i = 0; i < 40 && !SNDNMI; i++) begin
            step();
            if (!SNDNMI) cnt++;
        end
        check("b2b_gap", 16'(cnt), 16'd16);
        rd_cmd(8'h22, "b2b_rd2");
        step();
        check("b2b_nmi_low", {15'd0, SNDNMI}, 16'd0);

        // Simultaneous pop and push on a full queue.
        push_cmd(8'hAA, 1);
        push_cmd(8'hBB, 1);
        SCPU_AD   = 16'hE123;
        SCPU_MREQ = 1'b1;
        SCPU_RD   = 1'b1;
        step();
        SCPU_MREQ = 1'b0;
        SCPU_RD   = 1'b0;
        SNDRQ     = 1'b1;
        SNDNO     = 8'h33;
        step();
        SNDRQ = 1'b0;
        step();
        check("simul_ovr", {15'd0, OVERRUN}, 16'd0);
        rd_cmd(8'hBB, "simul_rd1");
        rd_cmd(8'h33, "simul_rd2");

        // Overrun: third push dropped.
        push_cmd(8'h01, 1);
        push_cmd(8'h02, 1);
        push_cmd(8'h03, 1);
        check("ovr_flag", {15'd0, OVERRUN}, 16'd1);
        rd_cmd(8'h01, "ovr_rd1");
        rd_cmd(8'h02, "ovr_rd2");
        check("ovr_empty", {8'd0, CMD_DO}, 16'h0000);

        // IRQ period and length.
        wait_rise(r1);
        cnt = 0;
        while (SNDIRQ && cnt < 50) begin
            cnt++;
            step();
        end
        check("irq_len", 16'(cnt), 16'(LEN));
        wait_rise(r2);
        check("irq_period", 16'(r2 - r1), 16'(DIV));

        // Acknowledge in the third asserted cycle.
        wait_rise(r3);
        step();
        step();
        check("iack_pre", {15'd0, SNDIRQ}, 16'd1);
        SCPU_IACK = 1'b1;
        step();
        SCPU_IACK = 1'b0;
        check("iack_clear", {15'd0, SNDIRQ}, 16'd0);

        // Pause for 50 cycles pushes the next IRQ 50 cycles later.
        repeat (10) step();
        PAUSE_N = 1'b0;
        repeat (50) step();
        PAUSE_N = 1'b1;
        wait_rise(r4);
        check("pause_period", 16'(r4 - r3), 16'(DIV + 50));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) SNDRQ = ~SNDRQ;
            SNDNO     = 8'($urandom());
            SCPU_AD   = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : {4'hE, 12'($urandom())};
            SCPU_MREQ = ($urandom_range(0, 1) == 0);
            SCPU_RD   = ($urandom_range(0, 2) != 0);
            SCPU_IACK = ($urandom_range(0, 15) == 0);
            PAUSE_N   = ($urandom_range(0, 9) != 0);
            step();
        end
        SNDRQ = 1'b0; SCPU_MREQ = 1'b0; SCPU_RD = 1'b0; SCPU_IACK = 1'b0; PAUSE_N = 1'b1;
        step();
        step();

        // Reset mid-queue, with the strobe held high across release.
        push_cmd(8'h44, 1);
        push_cmd(8'h55, 1);
        SNDRQ = 1'b1;
        SNDNO = 8'h77;
        RESET = 1'b1;
        #2;
        model_reset();
        check("rst_mid_do", {8'd0, CMD_DO}, 16'h0000);
        check("rst_mid_nmi", {15'd0, SNDNMI}, 16'd0);
        check("rst_mid_irq", {15'd0, SNDIRQ}, 16'd0);
        check("rst_mid_ovr", {15'd0, OVERRUN}, 16'd0);
        repeat (2) @(posedge CLK40M);
        @(negedge CLK40M);
        RESET = 1'b0;
        repeat (3) step();
        check("rst_no_push", {8'd0, CMD_DO}, 16'h0000);
        SNDRQ = 1'b0;
        step();
        push_cmd(8'h66, 1);
        check("post_rst_push", {8'd0, CMD_DO}, 16'h0066);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segasys1_sndcmd_rx.md
SEGASYS1_SNDCMD_RX -- requirements
Module: segasys1_sndcmd_rx

Interface
REQ-001 SHALL have parameter IRQ_DIV, default 160000: CLK40M cycles per periodic sound IRQ, giving 4 ms.
REQ-002 SHALL have parameter IRQ_LEN, default 2048: maximum SNDIRQ assertion, in CLK40M cycles.
REQ-003 SHALL have parameter NMI_GAP, default 16: SNDNMI forced-low cycles after each pop.
REQ-004 SHALL have port CLK40M  in  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port SNDRQ  in  1  sound request from main CPU; high for 1..N cycles per write.
REQ-007 SHALL have port SNDNO  in  8  command byte; valid on every cycle SNDRQ is high.
REQ-008 SHALL have port SCPU_AD  in  16  sound CPU address.
REQ-009 SHALL have port SCPU_MREQ  in  1  sound CPU memory request, active high.
REQ-010 SHALL have port SCPU_RD  in  1  sound CPU read strobe, active high.
REQ-011 SHALL have port SCPU_IACK  in  1  interrupt acknowledge (M1 & IORQ), active high.
REQ-012 SHALL have port PAUSE_N  in  1  low freezes the IRQ timer.
REQ-013 SHALL have port CMD_CS  out  1  read decode hit: SCPU_AD[15:12]==4'hE & SCPU_MREQ & SCPU_RD.
REQ-014 SHALL have port CMD_DO  out  8  queue head byte; 8'h00 when the queue is empty.
REQ-015 SHALL have port SNDNMI  out  1  command-pending NMI to sound CPU.
REQ-016 SHALL have port SNDIRQ  out  1  periodic IRQ to sound CPU.
REQ-017 SHALL have port OVERRUN  out  1  sticky flag: a command was dropped.

Function
REQ-018 SHALL push SNDNO into the command queue only on a SNDRQ rising edge (SNDRQ high, previous-cycle SNDRQ low), so a multi-cycle strobe pushes exactly once.
REQ-019 SHALL implement the queue as a 2-entry FIFO with count 0..2; CMD_DO SHALL be combinational from the head entry.
REQ-020 SHALL pop once per read cycle, in the first cycle CMD_CS is low after having been high; it SHALL NOT pop when the queue is empty.
REQ-021 SHALL, on push with count==2 and no simultaneous pop, drop the new byte, keep the queue unchanged, and set OVERRUN until reset.
REQ-022 SHALL, on simultaneous push and pop, accept both: count is unchanged and the new byte becomes the tail (or the head, if count was 1).
REQ-023 SHALL drive SNDNMI = (count!=0) & (gap counter==0).
REQ-024 SHALL load the gap counter with NMI_GAP on every pop and decrement it to 0, so a second queued command produces a fresh NMI edge.
REQ-025 SHALL run a free counter 0..IRQ_DIV-1 that wraps to 0; it advances only while PAUSE_N is high.
REQ-026 SHALL assert SNDIRQ on the cycle after the counter wraps.
REQ-027 SHALL clear SNDIRQ on SCPU_IACK high or after IRQ_LEN cycles asserted, whichever comes first.
REQ-028 SHALL NOT re-trigger SNDIRQ from a wrap that occurs while SNDIRQ is already high; that wrap is ignored.
REQ-029 SHALL hold the IRQ-length counter and SNDIRQ unchanged while PAUSE_N is low; the queue and NMI logic SHALL keep running.

Reset
REQ-030 SHALL, while RESET is high, force: queue empty (count 0), CMD_DO 8'h00, SNDNMI 0, SNDIRQ 0, OVERRUN 0, gap counter 0, IRQ counter 0, and SNDRQ edge register 0.
REQ-031 SHALL discard queued commands and abort in-progress IRQ/NMI on reset mid-operation.
REQ-032 SHALL NOT push when SNDRQ is already high as RESET deasserts.

Verification
REQ-033 Single command: SNDRQ high 3 cycles with SNDNO=8'h5A -> count 1, SNDNMI=1 one cycle after the edge; read $E000 -> CMD_DO 8'h5A, then SNDNMI=0 and count 0.
REQ-034 Back-to-back: push 8'h11 then 8'h22, then one read -> 8'h11, SNDNMI low 16 cycles then high; second read -> 8'h22, SNDNMI stays low.
REQ-035 Overrun: push 8'h01, 8'h02, 8'h03 with no reads -> OVERRUN=1; reads return 8'h01 then 8'h02.
REQ-036 Simultaneous: count 2 with pop and push 8'h33 in the same cycle -> count 2, OVERRUN=0, tail 8'h33.
REQ-037 IRQ: IRQ_DIV=100, IRQ_LEN=10 -> SNDIRQ rises every 100 cycles and lasts 10 cycles; SCPU_IACK on its 3rd cycle clears it in 3.
REQ-038 Pause and reset: PAUSE_N low for 50 cycles -> next IRQ is 50 cycles later; RESET mid-queue -> all outputs return to reset values immediately.
